tea_engine: RTL and testbench
=============================

Name: tea_engine

Overview:
- Parametrised, iterative TEA block cipher engine with encrypt and decrypt modes, configurable round count and rounds-per-clock unroll.
- Uses valid/ready handshakes on input and output so it can sit between a request FIFO and a result FIFO in the crypto datapath.
- Captures data, key and mode on acceptance, iterates the Feistel rounds, then holds the result until the consumer takes it.

Parameters:
- ROUNDS, 32: TEA cycles per block; legal range 1..64.
- UNROLL, 1: rounds evaluated per clock; must divide ROUNDS (1, 2, 4, ...).
- DELTA, 32'h9E3779B9: key-schedule constant.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  async active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  engine can accept a request.
- in_mode  in  1  0 = encrypt, 1 = decrypt.
- in_data  in  64  block {y,z}; y = [63:32].
- in_key  in  128  {k0,k1,k2,k3}; k0 = [127:96].
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- out_data  out  64  result {y,z}.
- busy  out  1  high in RUN or DONE.
- Interface rule: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset: async on rst_n low. State = IDLE; in_ready = 1; out_valid = 0; busy = 0; out_data, y, z, sum and the counter all = 0.
- IDLE: in_ready = 1.
  - On in_valid & in_ready, register y, z, key and mode, clear the counter, go to RUN.
  - Initial sum: encrypt = 0; decrypt = DELTA*ROUNDS mod 2^32, computed as a constant.
- RUN: in_ready = 0. Each clock applies UNROLL rounds; counter increments by 1. When counter = ROUNDS/UNROLL - 1, the final update lands and the state goes to DONE.
- Encrypt round, mod 2^32:
  - sum += DELTA
  - y += ((z<<4)+k0) ^ (z+sum) ^ ((z>>5)+k1)
  - z += ((y<<4)+k2) ^ (y+sum) ^ ((y>>5)+k3), using the new y.
- Decrypt round: z -= f(y, k2, k3, sum); then y -= f(z, k0, k1, sum) using the new z; then sum -= DELTA.
- Shifts are logical; all arithmetic truncates to 32 bits.
- DONE: out_valid = 1 and out_data = {y,z}, both stable until out_ready. On out_valid & out_ready, go to IDLE.
- Back-to-back traffic: in_ready stays 0 in DONE. Latency from accept to out_valid is exactly ROUNDS/UNROLL + 1 clocks (33 at defaults). Throughput is one block per ROUNDS/UNROLL + 2 clocks when out_ready is held high.
- Input changes after acceptance are ignored.
- in_valid with out_valid pending is not accepted.
- Counter width: $clog2(ROUNDS/UNROLL + 1).
- Reset mid-RUN or mid-DONE aborts immediately; no output is produced for that block.

Optional Feature:
- Macro: TEA_XTEA_EN.
- Defined:
  - Adds port in_algo (in, 1); 0 = TEA, 1 = XTEA. It is captured at accept.
  - XTEA encrypt: y += (((z<<4)^(z>>5))+z) ^ (sum+key[sum&3]); sum += DELTA; z += (((y<<4)^(y>>5))+y) ^ (sum+key[(sum>>11)&3]). Decrypt is the exact inverse.
  - key[i] indexes k0..k3.
- Undefined: no in_algo port; TEA only; no XTEA logic synthesised.

Decomposition:
- tea_pkg holds:
  - DELTA_DEFAULT
  - mode enum (MODE_ENC, MODE_DEC)
  - state enum (S_IDLE, S_RUN, S_DONE)
  - algo enum (ALGO_TEA, ALGO_XTEA)
  - key-word index constants
- Sub-module tea_round: combinational single round (encrypt/decrypt, plus XTEA under the macro), taking y, z, sum and key and returning the next y, z and sum. It is instantiated UNROLL times in a chain.

Test Plan:
- Encrypt, key = 0, data = 0, defaults: out_data = 64'h41EA3A0A_94BAA940; out_valid rises exactly 33 clocks after accept.
- Decrypt, key = 0, data = 64'h41EA3A0A_94BAA940: out_data = 0.
- Random key and data, 200 blocks, each encrypted then decrypted: round-trip equals the original data. Repeat with UNROLL = 4; latency must be 9 clocks.
- Hold out_ready low for 10 clocks in DONE: out_data stays stable, in_ready = 0 and a new in_valid is not accepted. Raise out_ready: the next request is accepted in IDLE.
- Drop rst_n at RUN cycle 15: outputs return to their reset values at once. After release, a fresh key = 0 encrypt still gives 41EA3A0A_94BAA940.
- With TEA_XTEA_EN, in_algo = 1, key = 0, data = 0, encrypt: out_data = 64'hDEE9D4D8_F7131ED9; decrypting that value returns 0.

Source files
------------

// File: rtl/tea_pkg.sv
// Shared types and constants for the TEA cipher engine.
// XTEA support is selected with the TEA_XTEA_EN macro.
package tea_pkg;

    localparam logic [31:0] DELTA_DEFAULT = 32'h9E3779B9;

    typedef enum logic {MODE_ENC = 1'b0, MODE_DEC = 1'b1} mode_e;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;
    typedef enum logic {ALGO_TEA = 1'b0, ALGO_XTEA = 1'b1} algo_e;

    localparam logic [1:0] KEY_K0 = 2'd0;
    localparam logic [1:0] KEY_K1 = 2'd1;
    localparam logic [1:0] KEY_K2 = 2'd2;
    localparam logic [1:0] KEY_K3 = 2'd3;

    // k0 sits in the most significant word of the 128-bit key.
    function automatic logic [31:0] key_word(input logic [127:0] key, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            KEY_K0:  w = key[127:96];
            KEY_K1:  w = key[95:64];
            KEY_K2:  w = key[63:32];
            default: w = key[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/tea_round.sv
// One combinational TEA (or, with TEA_XTEA_EN, XTEA) Feistel round in
// either direction; chained UNROLL times by tea_engine.
module tea_round
    import tea_pkg::*;
#(
    parameter logic [31:0] DELTA = DELTA_DEFAULT
) (
    input  logic [31:0]  y_i,
    input  logic [31:0]  z_i,
    input  logic [31:0]  sum_i,
    input  logic [127:0] key_i,
    input  mode_e        mode_i,
`ifdef TEA_XTEA_EN
    input  algo_e        algo_i,
`endif
    output logic [31:0]  y_o,
    output logic [31:0]  z_o,
    output logic [31:0]  sum_o
);

    function automatic logic [31:0] tea_f(input logic [31:0] v, input logic [31:0] ka,
                                          input logic [31:0] kb, input logic [31:0] s);
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

`ifdef TEA_XTEA_EN
    function automatic logic [31:0] xtea_f(input logic [31:0] v, input logic [31:0] s,
                                           input logic [31:0] k);
        return (((v << 4) ^ (v >> 5)) + v) ^ (s + k);
    endfunction
`endif

    logic [31:0] k0, k1, k2, k3;

    assign k0 = key_word(key_i, KEY_K0);
    assign k1 = key_word(key_i, KEY_K1);
    assign k2 = key_word(key_i, KEY_K2);
    assign k3 = key_word(key_i, KEY_K3);

    always_comb begin
        logic [31:0] s1;
        logic [31:0] h1;
        s1    = sum_i;
        h1    = '0;
        y_o   = y_i;
        z_o   = z_i;
        sum_o = sum_i;
`ifdef TEA_XTEA_EN
        if (algo_i == ALGO_XTEA) begin
            if (mode_i == MODE_ENC) begin
                h1    = y_i + xtea_f(z_i, sum_i, key_word(key_i, sum_i[1:0]));
                s1    = sum_i + DELTA;
                y_o   = h1;
                z_o   = z_i + xtea_f(h1, s1, key_word(key_i, s1[12:11]));
                sum_o = s1;
            end else begin
                h1    = z_i - xtea_f(y_i, sum_i, key_word(key_i, sum_i[12:11]));
                s1    = sum_i - DELTA;
                z_o   = h1;
                y_o   = y_i - xtea_f(h1, s1, key_word(key_i, s1[1:0]));
                sum_o = s1;
            end
        end else
`endif
        if (mode_i == MODE_ENC) begin
            s1    = sum_i + DELTA;
            h1    = y_i + tea_f(z_i, k0, k1, s1);
            y_o   = h1;
            z_o   = z_i + tea_f(h1, k2, k3, s1);
            sum_o = s1;
        end else begin
            // Decrypt undoes z first, using the sum before it is stepped back.
            h1    = z_i - tea_f(y_i, k2, k3, sum_i);
            z_o   = h1;
            y_o   = y_i - tea_f(h1, k0, k1, sum_i);
            sum_o = sum_i - DELTA;
        end
    end

endmodule

// File: rtl/tea_engine.sv
// Iterative TEA encrypt/decrypt engine with valid/ready on both sides.
// Define TEA_XTEA_EN to add the in_algo port and XTEA rounds.
module tea_engine
    import tea_pkg::*;
#(
    parameter int          ROUNDS = 32,
    parameter int          UNROLL = 1,
    parameter logic [31:0] DELTA  = DELTA_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
`ifdef TEA_XTEA_EN
    input  logic         in_algo,
`endif
    input  logic [63:0]  in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         busy
);

    localparam int STEPS = ROUNDS / UNROLL;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [63:0] SUM_PROD = 64'(DELTA) * 64'(ROUNDS);
    localparam logic [31:0] SUM_DEC  = SUM_PROD[31:0];

    state_e             state_q, state_d;
    logic [31:0]        y_q, y_d, z_q, z_d, sum_q, sum_d;
    logic [127:0]       key_q, key_d;
    mode_e              mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef TEA_XTEA_EN
    algo_e              algo_q, algo_d;
`endif

    logic [31:0] y_c   [UNROLL+1];
    logic [31:0] z_c   [UNROLL+1];
    logic [31:0] sum_c [UNROLL+1];

    assign y_c[0]   = y_q;
    assign z_c[0]   = z_q;
    assign sum_c[0] = sum_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        tea_round #(.DELTA(DELTA)) u_round (
            .y_i   (y_c[g]),
            .z_i   (z_c[g]),
            .sum_i (sum_c[g]),
            .key_i (key_q),
            .mode_i(mode_q),
`ifdef TEA_XTEA_EN
            .algo_i(algo_q),
`endif
            .y_o   (y_c[g+1]),
            .z_o   (z_c[g+1]),
            .sum_o (sum_c[g+1])
        );
    end

    assign out_data = {y_q, z_q};

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        z_d       = z_q;
        sum_d     = sum_q;
        key_d     = key_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
`ifdef TEA_XTEA_EN
        algo_d    = algo_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    y_d     = in_data[63:32];
                    z_d     = in_data[31:0];
                    key_d   = in_key;
                    mode_d  = in_mode ? MODE_DEC : MODE_ENC;
                    sum_d   = in_mode ? SUM_DEC : 32'd0;
                    cnt_d   = '0;
`ifdef TEA_XTEA_EN
                    algo_d  = in_algo ? ALGO_XTEA : ALGO_TEA;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                y_d   = y_c[UNROLL];
                z_d   = z_c[UNROLL];
                sum_d = sum_c[UNROLL];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            y_q     <= '0;
            z_q     <= '0;
            sum_q   <= '0;
            key_q   <= '0;
            mode_q  <= MODE_ENC;
            cnt_q   <= '0;
`ifdef TEA_XTEA_EN
            algo_q  <= ALGO_TEA;
`endif
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            z_q     <= z_d;
            sum_q   <= sum_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
`ifdef TEA_XTEA_EN
            algo_q  <= algo_d;
`endif
        end
    end

endmodule

// File: tb/tb_tea_engine.sv
// Bench for tea_engine: default and UNROLL=4 instances driven in lockstep,
// checked against a loop-level TEA/XTEA reference model.
module tb_tea_engine;

    localparam int          ROUNDS = 32;
    localparam logic [31:0] DELTA  = 32'h9E3779B9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid;
    logic         in_mode;
    logic [63:0]  in_data;
    logic [127:0] in_key;
    logic         out_ready;
`ifdef TEA_XTEA_EN
    logic         in_algo;
`endif

    logic        in_ready0, out_valid0, busy0;
    logic [63:0] out_data0;
    logic        in_ready4, out_valid4, busy4;
    logic [63:0] out_data4;

    int vectors     = 0;
    int miscompares = 0;

    tea_engine u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready0),
        .in_mode  (in_mode),
`ifdef TEA_XTEA_EN
        .in_algo  (in_algo),
`endif
        .in_data  (in_data),
        .in_key   (in_key),
        .out_valid(out_valid0),
        .out_ready(out_ready),
        .out_data (out_data0),
        .busy     (busy0)
    );

    tea_engine #(.ROUNDS(32), .UNROLL(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready4),
        .in_mode  (in_mode),
`ifdef TEA_XTEA_EN
        .in_algo  (in_algo),
`endif
        .in_data  (in_data),
        .in_key   (in_key),
        .out_valid(out_valid4),
        .out_ready(out_ready),
        .out_data (out_data4),
        .busy     (busy4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference cipher written straight from the round equations.
    function automatic logic [63:0] tea_ref(input logic [63:0] d, input logic [127:0] k,
                                            input bit dec, input bit xtea);
        logic [31:0] y, z, s;
        logic [31:0] kw [4];
        y = d[63:32];
        z = d[31:0];
        kw[0] = k[127:96];
        kw[1] = k[95:64];
        kw[2] = k[63:32];
        kw[3] = k[31:0];
        s = 32'd0;
        if (dec) for (int r = 0; r < ROUNDS; r++) s += DELTA;
        for (int r = 0; r < ROUNDS; r++) begin
            if (!dec && !xtea) begin
                s += DELTA;
                y += ((z << 4) + kw[0]) ^ (z + s) ^ ((z >> 5) + kw[1]);
                z += ((y << 4) + kw[2]) ^ (y + s) ^ ((y >> 5) + kw[3]);
            end else if (dec && !xtea) begin
                z -= ((y << 4) + kw[2]) ^ (y + s) ^ ((y >> 5) + kw[3]);
                y -= ((z << 4) + kw[0]) ^ (z + s) ^ ((z >> 5) + kw[1]);
                s -= DELTA;
            end else if (!dec) begin
                y += (((z << 4) ^ (z >> 5)) + z) ^ (s + kw[s[1:0]]);
                s += DELTA;
                z += (((y << 4) ^ (y >> 5)) + y) ^ (s + kw[s[12:11]]);
            end else begin
                z -= (((y << 4) ^ (y >> 5)) + y) ^ (s + kw[s[12:11]]);
                s -= DELTA;
                y -= (((z << 4) ^ (z >> 5)) + z) ^ (s + kw[s[1:0]]);
            end
        end
        return {y, z};
    endfunction

    // Submit one block to both engines, capture results and latencies, then drain.
    task automatic run_block(input logic mode, input logic [63:0] d, input logic [127:0] k,
                             output logic [63:0] r0, output logic [63:0] r4,
                             output int l0, output int l4);
        bit g0, g4;
        int cyc;
        g0 = 1'b0; g4 = 1'b0;
        l0 = -1;   l4 = -1;
        r0 = '0;   r4 = '0;
        @(negedge clk);
        check("in_ready_idle", {62'd0, in_ready0, in_ready4}, 64'd3);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = d;
        in_key   = k;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mode  = ~mode;
        in_data  = {$urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
        cyc = 1;
        while (!(g0 && g4) && cyc < 200) begin
            if (!g0 && out_valid0) begin g0 = 1'b1; l0 = cyc; r0 = out_data0; end
            if (!g4 && out_valid4) begin g4 = 1'b1; l4 = cyc; r4 = out_data4; end
            if (!(g0 && g4)) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]  r0, r4, d, c, exp, hold;
        logic [127:0] k;
        int           l0, l4, cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b0;
`ifdef TEA_XTEA_EN
        in_algo   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(in_ready0),  64'd1);
        check("rst_out_valid", 64'(out_valid0), 64'd0);
        check("rst_busy",      64'(busy0),      64'd0);
        check("rst_out_data",  out_data0,       64'd0);
        check("rst_out_data4", out_data4,       64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Known-answer vectors
        run_block(1'b0, 64'd0, 128'd0, r0, r4, l0, l4);
        check("kat_enc",       r0,       64'h41EA3A0A_94BAA940);
        check("kat_enc_u4",    r4,       64'h41EA3A0A_94BAA940);
        check("lat_u1",        64'(l0),  64'd33);
        check("lat_u4",        64'(l4),  64'd9);
        run_block(1'b1, 64'h41EA3A0A_94BAA940, 128'd0, r0, r4, l0, l4);
        check("kat_dec",       r0,       64'd0);
        check("kat_dec_u4",    r4,       64'd0);

        // Random round trips against the model
        for (int i = 0; i < 200; i++) begin
            d   = {$urandom, $urandom};
            k   = {$urandom, $urandom, $urandom, $urandom};
            exp = tea_ref(d, k, 1'b0, 1'b0);
            run_block(1'b0, d, k, r0, r4, l0, l4);
            check("rnd_enc",    r0, exp);
            check("rnd_enc_u4", r4, exp);
            check("rnd_lat_u1", 64'(l0), 64'd33);
            check("rnd_lat_u4", 64'(l4), 64'd9);
            c = r0;
            run_block(1'b1, c, k, r0, r4, l0, l4);
            check("rnd_dec",    r0, d);
            check("rnd_dec_u4", r4, tea_ref(c, k, 1'b1, 1'b0));
        end

        // Back-pressure: result held, new request refused until drained
        d = {$urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b0; in_data = d; in_key = k;
        @(posedge clk);
        #1;
        hold = tea_ref(d, k, 1'b0, 1'b0);
        in_data = ~d;
        cyc = 0;
        while (!out_valid0 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("bp_valid_seen", 64'(out_valid0), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_data_stable", out_data0, hold);
            check("bp_in_ready",    64'(in_ready0), 64'd0);
            check("bp_out_valid",   64'(out_valid0), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_drained",  64'(out_valid0), 64'd0);
        check("bp_idle_rdy", 64'(in_ready0),  64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_accepted", 64'(busy0), 64'd1);
        cyc = 0;
        while (!out_valid0 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("bp_next_result", out_data0, tea_ref(~d, k, 1'b0, 1'b0));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of a run
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b0;
        in_data = {$urandom, $urandom}; in_key = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("mid_busy",  64'(busy0),      64'd1);
        check("mid_valid", 64'(out_valid0), 64'd0);
        rst_n = 1'b0;
        #1;
        check("arst_busy",      64'(busy0),      64'd0);
        check("arst_in_ready",  64'(in_ready0),  64'd1);
        check("arst_out_valid", 64'(out_valid0), 64'd0);
        check("arst_out_data",  out_data0,       64'd0);
        check("arst_busy4",     64'(busy4),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(1'b0, 64'd0, 128'd0, r0, r4, l0, l4);
        check("post_rst_kat",    r0, 64'h41EA3A0A_94BAA940);
        check("post_rst_kat_u4", r4, 64'h41EA3A0A_94BAA940);

`ifdef TEA_XTEA_EN
        in_algo = 1'b1;
        run_block(1'b0, 64'd0, 128'd0, r0, r4, l0, l4);
        check("xtea_kat_enc",    r0, 64'hDEE9D4D8_F7131ED9);
        check("xtea_kat_enc_u4", r4, 64'hDEE9D4D8_F7131ED9);
        run_block(1'b1, 64'hDEE9D4D8_F7131ED9, 128'd0, r0, r4, l0, l4);
        check("xtea_kat_dec",    r0, 64'd0);
        check("xtea_kat_dec_u4", r4, 64'd0);
        for (int i = 0; i < 20; i++) begin
            d = {$urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            run_block(1'b0, d, k, r0, r4, l0, l4);
            check("xtea_rnd_enc", r0, tea_ref(d, k, 1'b0, 1'b1));
            c = r0;
            run_block(1'b1, c, k, r0, r4, l0, l4);
            check("xtea_rnd_dec", r0, d);
            check("xtea_rnd_dec_u4", r4, d);
        end
        in_algo = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
